mnist_batch_ctrl: RTL

MNIST_BATCH_CTRL -- requirements
Module: mnist_batch_ctrl

---
 rtl/mnist_pkg.sv | 35 +++
 rtl/mnist_cyc_timer.sv | 31 +++
 rtl/mnist_batch_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared types and default sizing for the MNIST batch controller.
package mnist_pkg;

  localparam int unsigned DEF_MAX_IMGS    = 20;
  localparam int unsigned DEF_IMG_BITS    = 6272;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CYC_W   = 20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_REPORT = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] pred;
    logic               match;
    logic [CYC_W-1:0]   cycles;
  } res_t;

  // A batch must contain at least one image and no more than max_imgs.
  function automatic logic count_in_range(input logic [IDX_W-1:0] n,
                                          input int unsigned      max_imgs);
    return (n != '0) && (32'(n) <= max_imgs);
  endfunction

endpackage

// File: rtl/mnist_cyc_timer.sv
// Saturating cycle counter with a limit flag, used to time one inference.
module mnist_cyc_timer
  import mnist_pkg::*;
#(
  parameter int unsigned CNT_W = CYC_W,
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A LIMIT above the saturation value can never fire.
  assign timeout_c = (32'(cnt) >= LIMIT);

endmodule

// File: rtl/mnist_batch_ctrl.sv
// Sequences a batch of images from memory through the accelerator and
// reports per-image prediction, match and latency.
module mnist_batch_ctrl
  import mnist_pkg::*;
#(
  parameter int unsigned MAX_IMGS    = DEF_MAX_IMGS,
  parameter int unsigned IMG_BITS    = DEF_IMG_BITS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic [IDX_W-1:0]    cmd_num_imgs,
  input  logic                cmd_abort,
  output logic                busy,
  output logic                batch_done,
  output logic                err_timeout,
  output logic                img_rd_en,
  output logic [IDX_W-1:0]    img_rd_addr,
  input  logic [IMG_BITS-1:0] img_rd_data,
  input  logic [DIGIT_W-1:0]  lbl_rd_data,
  output logic                acc_start,
  output logic [IMG_BITS-1:0] acc_img_data,
  input  logic [DIGIT_W-1:0]  acc_pred,
  input  logic                acc_done,
  output logic                res_valid,
  output logic [IDX_W-1:0]    res_idx,
  output logic [DIGIT_W-1:0]  res_pred,
  output logic                res_match,
  output logic [CYC_W-1:0]    res_cycles,
  output logic [IDX_W-1:0]    correct_cnt
);

  state_t             state;
  logic [IDX_W-1:0]   count;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] label;
  logic               arm;
  res_t               res;
  logic [CYC_W-1:0]   cyc;
  logic               tmo_c;
  logic               tmr_clr_c;
  logic               tmr_en_c;

  // Counter reads 0 in the acc_start cycle, so it equals cycles since start.
  assign tmr_clr_c = (state == S_LOAD);
  assign tmr_en_c  = (state == S_START) || (state == S_WAIT);

  mnist_cyc_timer #(
    .CNT_W (CYC_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .cnt       (cyc),
    .timeout_c (tmo_c)
  );

  assign res_idx    = res.idx;
  assign res_pred   = res.pred;
  assign res_match  = res.match;
  assign res_cycles = res.cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      idx          <= '0;
      label        <= '0;
      arm          <= 1'b0;
      res          <= '0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      err_timeout  <= 1'b0;
      img_rd_en    <= 1'b0;
      img_rd_addr  <= '0;
      acc_start    <= 1'b0;
      acc_img_data <= '0;
      res_valid    <= 1'b0;
      correct_cnt  <= '0;
    end else begin
      img_rd_en  <= 1'b0;
      acc_start  <= 1'b0;
      res_valid  <= 1'b0;
      batch_done <= 1'b0;

      // Abort beats everything, including a completion seen this cycle.
      if (cmd_abort && (state != S_IDLE) && (state != S_DONE)) begin
        batch_done <= 1'b1;
        state      <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start && count_in_range(cmd_num_imgs, MAX_IMGS)) begin
              count       <= cmd_num_imgs;
              idx         <= '0;
              correct_cnt <= '0;
              err_timeout <= 1'b0;
              img_rd_en   <= 1'b1;
              img_rd_addr <= '0;
              busy        <= 1'b1;
              state       <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            acc_img_data <= img_rd_data;
            label        <= lbl_rd_data;
            acc_start    <= 1'b1;
            arm          <= 1'b0;
            state        <= S_START;
          end
          S_START: state <= S_WAIT;
          S_WAIT: begin
            // Only a done that rises after a low sample counts as completion.
            if (!acc_done) begin
              arm <= 1'b1;
            end
            if (arm && acc_done) begin
              res       <= '{idx: idx, pred: acc_pred, match: (acc_pred == label), cycles: cyc};
              res_valid <= 1'b1;
              state     <= S_REPORT;
            end else if (tmo_c) begin
              res         <= '{idx: idx, pred: 4'hF, match: 1'b0, cycles: cyc};
              res_valid   <= 1'b1;
              err_timeout <= 1'b1;
              state       <= S_REPORT;
            end
          end
          S_REPORT: begin
            if (res.match) begin
              correct_cnt <= correct_cnt + IDX_W'(1);
            end
            if (idx == count - IDX_W'(1)) begin
              batch_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              idx         <= idx + IDX_W'(1);
              img_rd_addr <= idx + IDX_W'(1);
              img_rd_en   <= 1'b1;
              state       <= S_FETCH;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
